// File: rtl/apb_master_if.sv
// Bundles the command/response port and the APB bus of apb_master.
// The master modport is the requester's view; the slave modport is the opposite side
// (command source, response sink and APB completer together).
interface apb_master_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    // Command port
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;
    logic [STRB_WIDTH-1:0] cmd_strb;

    // Response port
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;
    logic                  rsp_timeout;

    // APB bus
    logic                  PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [ADDR_WIDTH-1:0] PADDR;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic [STRB_WIDTH-1:0] PSTRB;
    logic [DATA_WIDTH-1:0] PRDATA;
    logic                  PREADY;
    logic                  PSLVERR;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_master.sv
// APB requester: turns single-beat commands into SETUP/ACCESS transfers, returns each
// completion on a one-cycle response strobe and aborts transfers whose completer stalls
// for TIMEOUT consecutive ACCESS cycles (TIMEOUT = 0 disables the abort).
module apb_master #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic         PCLK,
    input  logic         PRESET,
    apb_master_if.master bus
);
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
    // Wide enough to hold TIMEOUT itself; one bit when the timeout is disabled
    localparam int unsigned CNT_WIDTH  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_WIDTH'(TIMEOUT - 1) : '0;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSetup  = 2'd1,
        StAccess = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [CNT_WIDTH-1:0]  wait_cnt_q, wait_cnt_d;

    logic                  psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic                  pwrite_q, pwrite_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic [STRB_WIDTH-1:0] pstrb_q, pstrb_d;

    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;
    logic                  rsp_timeout_q, rsp_timeout_d;

    logic                  timing_out;
    logic                  cmd_ready;
    logic                  accept;

    // Abort condition: last permitted stalled ACCESS cycle with the completer still not ready
    always_comb begin
        timing_out = 1'b0;
        if (TIMEOUT > 0) begin
            timing_out = (state_q == StAccess) && !bus.PREADY && (wait_cnt_q == CNT_LAST);
        end
    end

    // Command handshake: open in IDLE and on a clean ACCESS completion, never in reset
    always_comb begin
        cmd_ready = 1'b0;
        if (!PRESET) begin
            unique case (state_q)
                StIdle:   cmd_ready = 1'b1;
                StAccess: cmd_ready = bus.PREADY && !timing_out;
                default:  cmd_ready = 1'b0;
            endcase
        end
        accept = bus.cmd_valid && cmd_ready;
    end

    // Next-state and registered-output logic for the IDLE/SETUP/ACCESS sequencer
    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        pwrite_d      = pwrite_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        pstrb_d       = pstrb_q;
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;

        unique case (state_q)
            StIdle: begin
                psel_d    = 1'b0;
                penable_d = 1'b0;
            end
            StSetup: begin
                state_d   = StAccess;
                psel_d    = 1'b1;
                penable_d = 1'b1;
            end
            StAccess: begin
                if (bus.PREADY) begin
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = pwrite_q ? '0 : bus.PRDATA;
                    rsp_err_d     = bus.PSLVERR;
                    rsp_timeout_d = 1'b0;
                    state_d       = StIdle;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                end else if (timing_out) begin
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = '0;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                    state_d       = StIdle;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                end else if (wait_cnt_q != CNT_MAX) begin
                    // Saturate so a disabled timeout never wraps the counter
                    wait_cnt_d = wait_cnt_q + CNT_WIDTH'(1);
                end
            end
            default: begin
                state_d   = StIdle;
                psel_d    = 1'b0;
                penable_d = 1'b0;
            end
        endcase

        // A new command overrides the IDLE fall-back, giving back-to-back SETUP
        if (accept) begin
            state_d    = StSetup;
            wait_cnt_d = '0;
            psel_d     = 1'b1;
            penable_d  = 1'b0;
            pwrite_d   = bus.cmd_write;
            paddr_d    = bus.cmd_addr;
            pwdata_d   = bus.cmd_wdata;
            pstrb_d    = bus.cmd_write ? bus.cmd_strb : '0;
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q       <= StIdle;
            wait_cnt_q    <= '0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            pstrb_q       <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pwrite_q      <= pwrite_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            pstrb_q       <= pstrb_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign bus.cmd_ready   = cmd_ready;
    assign bus.PSEL        = psel_q;
    assign bus.PENABLE     = penable_q;
    assign bus.PWRITE      = pwrite_q;
    assign bus.PADDR       = paddr_q;
    assign bus.PWDATA      = pwdata_q;
    assign bus.PSTRB       = pstrb_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.rsp_timeout = rsp_timeout_q;

    // Address/data phase stays frozen while the completer inserts wait states
    a_stall_stable: assert property (@(posedge PCLK) disable iff (PRESET)
        (state_q == StAccess && !bus.PREADY && !timing_out)
        |=> $stable({paddr_q, pwdata_q, pwrite_q, pstrb_q}));

    // PENABLE is only ever raised inside a selected transfer
    a_enable_in_sel: assert property (@(posedge PCLK) disable iff (PRESET)
        penable_q |-> psel_q);
endmodule
